// File: rtl/health_alarm_sequencer.sv
// Debounces five health sources into pending events and serves them one at a time, fixed priority, on a valid/ack alarm port.
// Latency: DEBOUNCE_CYCLES edges to pending, +1 edge to alarmValid; alarmValid holds until alarmAck, then at least 2 idle cycles.
module health_alarm_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [3:0]  GLYCEMIC_LIMIT  = 4'd10,
  parameter int unsigned ACK_TIMEOUT     = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             presureAbnormality,
  input  logic             bloodAbnormality,
  input  logic             fallDetected,
  input  logic [3:0]       glycemicIndex,
  input  logic             temperatureAbnormality,
  input  logic             alarmAck,
  output logic             alarmValid,
  output logic [2:0]       alarmCode,
  output logic             escalate,
  output logic [4:0]       pendingMask,
  output logic [CNT_W-1:0] eventCount
);

  localparam int unsigned TO_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [3:0]  DB_MAX = 4'(DEBOUNCE_CYCLES);
  localparam logic [3:0]  DB_PRE = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ALARM, GAP} stateT;

  stateT            state, stateNxt;
  logic [4:0]       raw, qualify, clearMask, pendNxt;
  logic [3:0]       dbCnt [5];
  logic [2:0]       topIdx, served, servedNxt, codeNxt;
  logic [TO_W-1:0]  toCnt, toNxt;
  logic             validNxt, escNxt;
  logic [CNT_W-1:0] cntNxt;

  // Bit order doubles as priority: bit 0 (fall) is served first.
  assign raw = {glycemicIndex > GLYCEMIC_LIMIT, temperatureAbnormality,
                bloodAbnormality, presureAbnormality, fallDetected};

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 5; i++) dbCnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (!raw[i])              dbCnt[i] <= '0;
        else if (dbCnt[i] != DB_MAX) dbCnt[i] <= dbCnt[i] + 4'd1;
      end
    end
  end

  // One qualifying pulse per continuous high run, on the edge the counter reaches DB_MAX.
  always_comb begin
    qualify = '0;
    for (int i = 0; i < 5; i++) qualify[i] = raw[i] && (dbCnt[i] == DB_PRE);
  end

  always_comb begin
    topIdx = '0;
    for (int i = 4; i >= 0; i--) if (pendingMask[i]) topIdx = 3'(i);
  end

  always_comb begin
    stateNxt  = state;
    validNxt  = alarmValid;
    codeNxt   = alarmCode;
    escNxt    = escalate;
    toNxt     = toCnt;
    servedNxt = served;
    cntNxt    = eventCount;
    clearMask = '0;
    case (state)
      IDLE: begin
        validNxt = 1'b0;
        codeNxt  = '0;
        escNxt   = 1'b0;
        toNxt    = '0;
        if (|pendingMask) begin
          servedNxt = topIdx;
          codeNxt   = topIdx + 3'd1;
          validNxt  = 1'b1;
          stateNxt  = ALARM;
        end
      end
      ALARM: begin
        if (alarmAck) begin
          clearMask = 5'b00001 << served;
          if (eventCount != {CNT_W{1'b1}}) cntNxt = eventCount + 1'b1;
          validNxt = 1'b0;
          codeNxt  = '0;
          escNxt   = 1'b0;
          toNxt    = '0;
          stateNxt = GAP;
        end else begin
          if (toCnt != TO_MAX) toNxt = toCnt + 1'b1;
          escNxt = escalate | (toNxt == TO_MAX);
        end
      end
      GAP: begin
        validNxt = 1'b0;
        codeNxt  = '0;
        stateNxt = IDLE;
      end
      default: begin
        validNxt = 1'b0;
        codeNxt  = '0;
        escNxt   = 1'b0;
        toNxt    = '0;
        stateNxt = IDLE;
      end
    endcase
    // A re-qualification on the ack edge wins over the clear.
    pendNxt = (pendingMask & ~clearMask) | qualify;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= IDLE;
      alarmValid  <= 1'b0;
      alarmCode   <= '0;
      escalate    <= 1'b0;
      toCnt       <= '0;
      served      <= '0;
      eventCount  <= '0;
      pendingMask <= '0;
    end else begin
      state       <= stateNxt;
      alarmValid  <= validNxt;
      alarmCode   <= codeNxt;
      escalate    <= escNxt;
      toCnt       <= toNxt;
      served      <= servedNxt;
      eventCount  <= cntNxt;
      pendingMask <= pendNxt;
    end
  end

endmodule

// File: tb/tb_health_alarm_sequencer.sv
// Directed bench: stimulus queues expected alarm codes, a negedge monitor checks each presented alarm.
module tb_health_alarm_sequencer;

  logic       clk = 1'b0;
  logic       rstN;
  logic       press, blood, fall, temp, alarmAck;
  logic [3:0] glyc;
  logic       alarmValid, escalate;
  logic [2:0] alarmCode;
  logic [4:0] pendingMask;
  logic [7:0] eventCount;

  int total = 0;
  int bad   = 0;
  int expQ[$];
  int expCode;
  logic       prevValid = 1'b0;
  logic [2:0] prevCode  = 3'd0;

  health_alarm_sequencer dut (
    .clk                    (clk),
    .rstN                   (rstN),
    .presureAbnormality     (press),
    .bloodAbnormality       (blood),
    .fallDetected           (fall),
    .glycemicIndex          (glyc),
    .temperatureAbnormality (temp),
    .alarmAck               (alarmAck),
    .alarmValid             (alarmValid),
    .alarmCode              (alarmCode),
    .escalate               (escalate),
    .pendingMask            (pendingMask),
    .eventCount             (eventCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic waitValid(input string name, input int bound);
    int n = 0;
    while (!alarmValid && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!alarmValid) begin
      total++;
      bad++;
      $display("FAIL %s: alarmValid got 0 expected 1 within %0d cycles", name, bound);
    end
  endtask

  task automatic doAck();
    alarmAck = 1'b1;
    @(negedge clk);
    alarmAck = 1'b0;
  endtask

  always @(negedge clk) begin
    if (alarmValid && !prevValid) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_alarm: got code %0d expected none", alarmCode);
      end else begin
        expCode = expQ.pop_front();
        chk("alarm_code", int'(alarmCode), expCode);
      end
    end else if (alarmValid && prevValid) begin
      chk("code_stable", int'(alarmCode), int'(prevCode));
    end
    prevValid = alarmValid;
    prevCode  = alarmCode;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every input active
    rstN = 1'b0; press = 1; blood = 1; fall = 1; temp = 1; glyc = 4'd15; alarmAck = 1;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(alarmValid), 0);
    chk("rst_code", int'(alarmCode), 0);
    chk("rst_escalate", int'(escalate), 0);
    chk("rst_pending", int'(pendingMask), 0);
    chk("rst_count", int'(eventCount), 0);
    alarmAck = 0;
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rel_valid", int'(alarmValid), 0);
      chk("rel_pending", int'(pendingMask), 0);
    end
    press = 0; blood = 0; fall = 0; temp = 0; glyc = 4'd0;
    repeat (4) @(negedge clk);
    chk("rel_glitch_pending", int'(pendingMask), 0);

    // Single fall event, exact latency
    expQ.push_back(1);
    fall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fall_pre_pending", int'(pendingMask), 0);
    end
    @(negedge clk);
    chk("fall_pending_e4", int'(pendingMask), 1);
    chk("fall_valid_e4", int'(alarmValid), 0);
    @(negedge clk);
    chk("fall_valid_e5", int'(alarmValid), 1);
    doAck();
    chk("fall_ack_valid", int'(alarmValid), 0);
    chk("fall_count", int'(eventCount), 1);
    fall = 0;
    @(negedge clk);

    // Three-cycle pressure glitch
    press = 1;
    repeat (3) @(negedge clk);
    press = 0;
    repeat (6) @(negedge clk);
    chk("glitch_pending", int'(pendingMask), 0);
    chk("glitch_valid", int'(alarmValid), 0);

    // Pressure and temperature on the same edge
    expQ.push_back(2);
    expQ.push_back(4);
    press = 1; temp = 1;
    repeat (4) @(negedge clk);
    chk("dual_pending", int'(pendingMask), 5'b01010);
    press = 0; temp = 0;
    waitValid("dual_first", 4);
    doAck();
    chk("dual_gap1", int'(alarmValid), 0);
    @(negedge clk);
    chk("dual_gap2", int'(alarmValid), 0);
    @(negedge clk);
    chk("dual_second_valid", int'(alarmValid), 1);
    chk("dual_second_code", int'(alarmCode), 4);
    doAck();
    chk("dual_count", int'(eventCount), 3);
    chk("dual_pending_clr", int'(pendingMask), 0);

    // Glycemic threshold and escalation
    glyc = 4'd10;
    repeat (8) @(negedge clk);
    chk("glyc10_pending", int'(pendingMask), 0);
    expQ.push_back(5);
    glyc = 4'd11;
    waitValid("glyc11", 10);
    chk("esc_start", int'(escalate), 0);
    repeat (15) @(negedge clk);
    chk("esc_early", int'(escalate), 0);
    repeat (2) @(negedge clk);
    chk("esc_set", int'(escalate), 1);
    chk("esc_code", int'(alarmCode), 5);
    doAck();
    chk("esc_cleared", int'(escalate), 0);
    chk("esc_count", int'(eventCount), 4);
    glyc = 4'd0;
    repeat (2) @(negedge clk);

    // No preemption by a higher-priority fall
    expQ.push_back(4);
    temp = 1;
    waitValid("temp_alarm", 8);
    temp = 0;
    expQ.push_back(1);
    fall = 1;
    repeat (5) @(negedge clk);
    chk("nopre_pending", int'(pendingMask), 5'b01001);
    chk("nopre_code", int'(alarmCode), 4);
    fall = 0;
    doAck();
    chk("nopre_count", int'(eventCount), 5);
    waitValid("fall_after", 4);

    // Asynchronous reset in the middle of the fall alarm
    #2 rstN = 1'b0;
    #1;
    chk("arst_valid", int'(alarmValid), 0);
    chk("arst_code", int'(alarmCode), 0);
    chk("arst_pending", int'(pendingMask), 0);
    chk("arst_count", int'(eventCount), 0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_valid", int'(alarmValid), 0);
    chk("post_rst_pending", int'(pendingMask), 0);

    chk("queue_empty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
